slc3_mem_ctrl: RTL
==================

Name: slc3_mem_ctrl

Overview:
- Sequences every SLC-3 CPU memory access onto the external asynchronous SRAM.
- Decodes memory-mapped I/O: switch input and hex-display register.
- Sits between the CPU's MAR/MDR request interface and the SRAM pins plus board I/O in the slc3 top level.
- Inserts a fixed number of SRAM wait states and returns a one-cycle completion pulse.

Parameters:
WAIT_CYCLES, 2, SRAM access cycles with strobes asserted; legal range 1..15
IO_ADDR, 16'hFFFF, memory-mapped I/O address: read = switches, write = hex register

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  asynchronous, active-low reset
mem_req  in  1  CPU access request; level, sampled only in IDLE
mem_we  in  1  1 = write, 0 = read; sampled with mem_req
mem_addr  in  16  CPU address (MAR)
mem_wdata  in  16  CPU write data (MDR)
mem_rdata  out  16  read data; valid from mem_ready onward
mem_ready  out  1  one-cycle completion pulse
SW  in  10  board switches
hex_data  out  16  hex-display register, decoded externally
sram_ce_n  out  1  SRAM chip enable, active-low
sram_oe_n  out  1  SRAM output enable, active-low
sram_we_n  out  1  SRAM write enable, active-low
sram_addr  out  16  SRAM address
sram_din  in  16  data from SRAM
sram_dout  out  16  data to SRAM
sram_dout_en  out  1  tristate enable for sram_dout

Behaviour:

Reset (asynchronous, Reset=0):
- State=IDLE.
- mem_ready=0, mem_rdata=0, hex_data=0.
- sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
- sram_addr=0, sram_dout=0, sram_dout_en=0.
- Reset mid-access aborts immediately: strobes deassert asynchronously and no mem_ready is issued.

States: IDLE, ACCESS, DONE, IO_DONE.

IDLE:
- On a rising edge with mem_req=1, latch mem_addr, mem_we and mem_wdata into internal registers.
- If mem_addr==IO_ADDR, go to IO_DONE.
- Otherwise go to ACCESS and load the wait counter with WAIT_CYCLES-1.

ACCESS:
- sram_ce_n=0 and sram_addr=latched address.
- Read: sram_oe_n=0.
- Write: sram_we_n=0, sram_dout=latched data, sram_dout_en=1.
- Counter decrements each cycle; at 0 go to DONE.
- Read: on the transition edge, mem_rdata <= sram_din.

DONE:
- One cycle; mem_ready=1.
- All strobes high.
- Write: sram_dout_en stays 1 for data hold, then drops in IDLE.
- Always returns to IDLE.

IO_DONE:
- One cycle; mem_ready=1; no SRAM strobes.
- Read: mem_rdata was loaded with {6'b0, SW} on the IDLE→IO_DONE edge.
- Write: hex_data was loaded with the latched data on the same edge.
- Returns to IDLE.

Latency:
- mem_req sampled at edge k.
- SRAM access: mem_ready high during cycle k+WAIT_CYCLES+1.
- I/O access: mem_ready high during cycle k+1.

Rules and boundary conditions:
- mem_req and mem_addr/mem_wdata changes outside IDLE are ignored. CPU holds mem_req until mem_ready. The controller re-samples only in IDLE, so one idle cycle always separates back-to-back accesses.
- mem_rdata holds its value until the next completed read; writes do not disturb it.
- hex_data changes only on an I/O write.
- Write to IO_ADDR never reaches SRAM. Read of IO_ADDR never asserts sram_ce_n.
- sram_oe_n and sram_we_n are never low in the same cycle.
- WAIT_CYCLES=1: ACCESS lasts exactly one cycle.
- Address 16'hFFFE is a normal SRAM access (no partial decode).

Decomposition:
- Package slc3_mem_pkg holds:
  - state enum typedef mem_state_t {IDLE, ACCESS, DONE, IO_DONE};
  - constant IO_ADDR_DEFAULT = 16'hFFFF;
  - typedef word_t = logic [15:0].
- One sub-module is natural: slc3_io_regs. It owns the hex_data register and the SW read mux, is enabled by the FSM in the IDLE→IO_DONE transition, and uses the same Clk/Reset.
- Wait counter stays inline in the FSM.

Test Plan:
All cases use WAIT_CYCLES=2.
1. Reset asserted mid-ACCESS of a write to x3000 → sram_we_n=1, sram_ce_n=1 and sram_dout_en=0 immediately, asynchronously. No mem_ready after release. State IDLE.
2. Read x3000, SRAM model returns x1234 → sram_oe_n low for exactly 2 cycles, mem_ready pulses once at k+3, mem_rdata=x1234 and held afterwards.
3. Write xBEEF to x0042 → sram_we_n low for 2 cycles with sram_addr=x0042 and sram_dout=xBEEF. sram_dout_en high 3 cycles. mem_ready at k+3. SRAM model x0042=xBEEF.
4. SW=10'h2A5, read xFFFF → mem_ready at k+1, mem_rdata=x02A5, sram_ce_n stays 1 throughout.
5. Write x00C3 to xFFFF → hex_data=x00C3 at k+1. No SRAM strobes. Subsequent SRAM read of x3000 leaves hex_data=x00C3.
6. mem_req held high continuously for three reads → each separated by one IDLE cycle, mem_ready period 4 cycles. Address change during ACCESS does not alter sram_addr.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// slc3_mem_pkg: shared types and constants for the SLC-3 memory controller
package slc3_mem_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, IO_DONE} mem_state_t;

    typedef logic [15:0] word_t;

    localparam word_t IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/slc3_io_regs.sv
// slc3_io_regs: hex-display register and switch read mux for the memory-mapped I/O word
module slc3_io_regs
    import slc3_mem_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       en,
    input  logic       we,
    input  word_t      wdata,
    input  logic [9:0] SW,
    output word_t      hex_data,
    output word_t      io_rdata
);

    assign io_rdata = {6'b0, SW};

    // hex register only moves on an I/O write accepted from IDLE
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            hex_data <= '0;
        else if (en && we)
            hex_data <= wdata;
    end

endmodule

// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl: sequences CPU MAR/MDR accesses onto async SRAM with fixed wait states and memory-mapped I/O
module slc3_mem_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int    WAIT_CYCLES = 2,
    parameter word_t IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    input  logic [9:0]  SW,
    output logic [15:0] hex_data,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [15:0] sram_addr,
    input  logic [15:0] sram_din,
    output logic [15:0] sram_dout,
    output logic        sram_dout_en
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    mem_state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    word_t      addr_q, wdata_q, io_rdata;
    logic       we_q;

    wire accept  = (state == IDLE) && mem_req;
    wire io_hit  = accept && (mem_addr == IO_ADDR);
    wire last    = (state == ACCESS) && (cnt == 4'd0);
    wire in_acc  = (state == ACCESS);

    slc3_io_regs u_io (
        .Clk      (Clk),
        .Reset    (Reset),
        .en       (io_hit),
        .we       (mem_we),
        .wdata    (mem_wdata),
        .SW       (SW),
        .hex_data (hex_data),
        .io_rdata (io_rdata)
    );

    // state, wait counter and request latches; request fields are captured only when accepted in IDLE
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                we_q    <= mem_we;
            end
        end
    end

    // read data is loaded on the completing edge of a read, from SRAM or the switches, and otherwise held
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            mem_rdata <= '0;
        else if (io_hit && !mem_we)
            mem_rdata <= io_rdata;
        else if (last && !we_q)
            mem_rdata <= sram_din;
    end

    // next state: I/O hits skip the SRAM entirely; ACCESS counts down the wait states
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                state_nxt = accept ? (io_hit ? IO_DONE : ACCESS) : IDLE;
                cnt_nxt   = accept ? CNT_LOAD : cnt;
            end
            ACCESS: begin
                state_nxt = last ? DONE : ACCESS;
                cnt_nxt   = last ? cnt : cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // strobes decode straight from state so an asynchronous reset drops them immediately;
    // write data stays driven through DONE for hold time
    assign sram_ce_n    = !in_acc;
    assign sram_oe_n    = !(in_acc && !we_q);
    assign sram_we_n    = !(in_acc && we_q);
    assign sram_addr    = addr_q;
    assign sram_dout    = wdata_q;
    assign sram_dout_en = we_q && (in_acc || state == DONE);
    assign mem_ready    = (state == DONE) || (state == IO_DONE);

endmodule
